rcc_cpu_lp_mode_ctrl: RTL

RCC_CPU_LP_MODE_CTRL -- requirements
Module: rcc_cpu_lp_mode_ctrl

---
 rtl/rcc_cpu_lp_mode_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rcc_cpu_lp_mode_ctrl.sv
// CPU low-power mode sequencer: WFI/WFE entry filter, sleep / deep-sleep handshake
// with the power controller, and clock-stabilisation wait on deep-sleep exit.
module rcc_cpu_lp_mode_ctrl #(
    parameter int unsigned ENTRY_DLY = 4,
    parameter int unsigned WAKE_DLY  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_sleeping,
    input  logic       cpu_sleepdeep,
    input  logic       wakeup_evt,
    input  logic       pwr_ack,
    input  logic       pwr_ready,
    input  logic       ds_flag_clr,
    output logic       cpu_sleep,
    output logic       cpu_deepsleep,
    output logic       pwr_req,
    output logic [2:0] lp_state,
    output logic       ds_flag
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        ENTRY     = 3'd1,
        SLEEP     = 3'd2,
        DS_REQ    = 3'd3,
        DEEPSLEEP = 3'd4,
        EXIT      = 3'd5,
        WAKE      = 3'd6
    } lp_state_t;

    localparam logic [3:0] ENTRY_LOAD = 4'(ENTRY_DLY - 1);
    localparam logic [3:0] WAKE_LOAD  = 4'(WAKE_DLY - 1);

    lp_state_t  state_r;
    lp_state_t  state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       sleep_s;
    logic       deep_s;
    logic       req_s;
    logic       flag_s;

    // Next-state, delay counter, and output decode of the next state so outputs come from flops.
    always_comb begin
        state_s = state_r;
        cnt_s   = 4'd0;
        sleep_s = 1'b0;
        deep_s  = 1'b0;
        req_s   = 1'b0;
        flag_s  = ds_flag;

        case (state_r)
            RUN: begin
                if (cpu_sleeping && !wakeup_evt) begin
                    state_s = ENTRY;
                    cnt_s   = ENTRY_LOAD;
                end else begin
                    state_s = RUN;
                end
            end
            ENTRY: begin
                if (!cpu_sleeping || wakeup_evt) begin
                    state_s = RUN;
                end else if (cnt_r == 4'd0) begin
                    state_s = cpu_sleepdeep ? DS_REQ : SLEEP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            SLEEP: begin
                if (wakeup_evt || !cpu_sleeping) begin
                    state_s = RUN;
                end else begin
                    state_s = SLEEP;
                end
            end
            DS_REQ: begin
                // A wakeup withdraws the request even if the ack lands in the same cycle.
                if (wakeup_evt) begin
                    state_s = RUN;
                end else if (pwr_ack) begin
                    state_s = DEEPSLEEP;
                end else begin
                    state_s = DS_REQ;
                end
            end
            DEEPSLEEP: begin
                if (wakeup_evt) begin
                    state_s = EXIT;
                end else begin
                    state_s = DEEPSLEEP;
                end
            end
            EXIT: begin
                if (pwr_ready) begin
                    state_s = WAKE;
                    cnt_s   = WAKE_LOAD;
                end else begin
                    state_s = EXIT;
                end
            end
            WAKE: begin
                if (cnt_r == 4'd0) begin
                    state_s = RUN;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase

        case (state_s)
            SLEEP:     sleep_s = 1'b1;
            DS_REQ:    begin sleep_s = 1'b1; req_s = 1'b1; end
            DEEPSLEEP: begin sleep_s = 1'b1; deep_s = 1'b1; req_s = 1'b1; end
            EXIT:      begin sleep_s = 1'b1; deep_s = 1'b1; end
            WAKE:      sleep_s = 1'b1;
            default:   sleep_s = 1'b0;
        endcase

        // Entering deep sleep sets the flag and wins over a same-cycle clear.
        if (state_r == DS_REQ && state_s == DEEPSLEEP) begin
            flag_s = 1'b1;
        end else if (ds_flag_clr) begin
            flag_s = 1'b0;
        end else begin
            flag_s = ds_flag;
        end
    end

    // State, counter and output registers; reset drops power request and gates immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN;
            cnt_r         <= 4'd0;
            cpu_sleep     <= 1'b0;
            cpu_deepsleep <= 1'b0;
            pwr_req       <= 1'b0;
            ds_flag       <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            cpu_sleep     <= sleep_s;
            cpu_deepsleep <= deep_s;
            pwr_req       <= req_s;
            ds_flag       <= flag_s;
        end
    end

    assign lp_state = state_r;

endmodule
